// File: rtl/fb_vport.sv
// Framebuffer video port: buffers an RGB555 pixel stream in a small FIFO and
// replays it into DVI timing, locking onto the start-of-frame flag.
module fb_vport #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   FIFO_DEPTH = 16
) (
    input  logic        iCLK,
    input  logic        iRESETn,
    input  logic [14:0] iST_DATA,
    input  logic        iST_START,
    input  logic        iST_DV,
    output logic        oST_READY,
    output logic [7:0]  oRED,
    output logic [7:0]  oGRN,
    output logic [7:0]  oBLU,
    output logic        oHS,
    output logic        oVS,
    output logic        oDE,
    output logic        oLOCKED,
    output logic        oERR,
    output logic        oFRAME
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_MAX    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_MAX    = VW'(V_TOTAL - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_WAIT_FRAME,
        ST_RUN
    } state_t;

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0] r_red, r_grn, r_blu;
    logic       r_hs, r_vs, r_de, r_err, r_frame;

    logic        w_de, w_hs_act, w_vs_act, w_origin;
    logic        w_push, w_pop, w_show, w_err, w_empty, w_head_start;
    logic [15:0] w_head;

    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    assign w_de     = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
    assign w_hs_act = (r_hcnt >= H_SYNC_S) && (r_hcnt < H_SYNC_E);
    assign w_vs_act = (r_vcnt >= V_SYNC_S) && (r_vcnt < V_SYNC_E);
    assign w_origin = (r_hcnt == '0) && (r_vcnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == H_MAX) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == V_MAX) ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    assign oST_READY    = (r_count < DEPTH_C);
    assign w_push       = iST_DV && oST_READY;
    assign w_empty      = (r_count == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_start = w_head[15];

    // NOTE: the pixel storage has no reset; only pointers and count need clearing to empty it.
    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {iST_START, iST_DATA};
        end
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) r_state <= ST_SEARCH;
        else          r_state <= w_state_nxt;
    end

    // NOTE: every output of this block is defaulted first so no latches are inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_show      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (!w_empty) begin
                    if (w_head_start) w_state_nxt = ST_WAIT_FRAME;
                    else              w_pop       = 1'b1;
                end
            end
            ST_WAIT_FRAME: begin
                if (w_origin && !w_empty) begin
                    if (w_head_start) begin
                        w_pop       = 1'b1;
                        w_show      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_SEARCH;
                    end
                end
            end
            ST_RUN: begin
                if (w_de) begin
                    if (w_empty) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_SEARCH;
                    end else if (w_head_start && !w_origin) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_WAIT_FRAME;
                    end else if (!w_head_start && w_origin) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_SEARCH;
                    end else begin
                        w_pop  = 1'b1;
                        w_show = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_SEARCH;
        endcase
    end

    // Video outputs lag the counters by one clock; pixel and syncs stay aligned.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            r_red   <= '0;
            r_grn   <= '0;
            r_blu   <= '0;
            r_de    <= 1'b0;
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
            r_err   <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_red   <= w_show ? expand5(w_head[14:10]) : '0;
            r_grn   <= w_show ? expand5(w_head[9:5])   : '0;
            r_blu   <= w_show ? expand5(w_head[4:0])   : '0;
            r_de    <= w_de;
            r_hs    <= w_hs_act ? HS_POL : ~HS_POL;
            r_vs    <= w_vs_act ? VS_POL : ~VS_POL;
            r_err   <= w_err;
            r_frame <= w_origin;
        end
    end

    assign oRED    = r_red;
    assign oGRN    = r_grn;
    assign oBLU    = r_blu;
    assign oDE     = r_de;
    assign oHS     = r_hs;
    assign oVS     = r_vs;
    assign oERR    = r_err;
    assign oFRAME  = r_frame;
    assign oLOCKED = (r_state == ST_RUN);

endmodule
